// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage.
// Performs loads and stores against a data memory that answers with a
// one-cycle dmem_ack pulse. The stage also resolves branches and jumps, and
// holds the MEM/WB pipeline register.
//
// Handshake: dmem_req is high exactly while the FSM is in ACCESS. During that
// time dmem_addr, dmem_we and dmem_wdata stay constant. The memory completes
// the request with a single-cycle dmem_ack, and dmem_rdata is valid in that
// same cycle. Any ack that arrives outside ACCESS has no effect.
// While mem_stall is high, upstream stages must hold their EX/MEM values.
// That is why the EX/MEM fields are still valid when the ack arrives.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] reg2_data_mem,
  input  logic        zero_mem,
  input  logic        branch_flag_mem,
  input  logic        jump_flag_mem,
  input  logic [4:0]  write_reg_addr_mem,
  input  logic        mem_to_reg_flag_mem,
  input  logic        reg_write_flag_mem,
  input  logic        mem_read_flag_mem,
  input  logic        mem_write_flag_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        pc_src,
  output logic        mem_err,
  output logic [31:0] pc_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] read_data_wb,
  output logic [4:0]  write_reg_addr_wb,
  output logic        mem_to_reg_flag_wb,
  output logic        reg_write_flag_wb,
  output logic        fsm_state
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        access, aligned, timeout;
  logic        stall_c, start_c, set_err_c, cnt_inc_c, wb_load_c, finish_c;
  logic [31:0] wb_rdata_c;

  assign access    = mem_read_flag_mem | mem_write_flag_mem;
  assign aligned   = (alu_result_mem[1:0] == 2'b00);
  assign timeout   = (state == ACCESS) && !dmem_ack && (wait_cnt == TMO_LAST);
  assign dmem_req  = (state == ACCESS);
  assign fsm_state = (state == ACCESS);
  // Stall is forced low while reset is asserted.
  assign mem_stall = rst & stall_c;

  // Branch/jump redirect, purely combinational.
  assign pc_src = (branch_flag_mem & zero_mem) | jump_flag_mem;

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_nxt  = state;
    stall_c    = 1'b0;
    start_c    = 1'b0;
    set_err_c  = 1'b0;
    cnt_inc_c  = 1'b0;
    wb_load_c  = 1'b0;
    finish_c   = 1'b0;
    wb_rdata_c = 32'd0;
    case (state)
      IDLE: begin
        if (access && aligned) begin
          stall_c   = 1'b1;
          start_c   = 1'b1;
          state_nxt = ACCESS;
        end else if (access) begin
          set_err_c = 1'b1;
        end else begin
          wb_load_c = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          // A combined read+write is a store, so no load data is returned.
          wb_load_c  = 1'b1;
          wb_rdata_c = dmem_we ? 32'd0 : dmem_rdata;
          finish_c   = 1'b1;
          state_nxt  = IDLE;
        end else if (timeout) begin
          set_err_c = 1'b1;
          finish_c  = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_c   = 1'b1;
          cnt_inc_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Wait counter: cleared when a request starts, counts cycles without ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           wait_cnt <= 8'd0;
    else if (start_c)   wait_cnt <= 8'd0;
    else if (cnt_inc_c) wait_cnt <= wait_cnt + 8'd1;
  end

  // Request attributes are captured once and then held for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
    end else if (start_c) begin
      dmem_we    <= mem_write_flag_mem;
      dmem_addr  <= alu_result_mem;
      dmem_wdata <= reg2_data_mem;
    end else if (finish_c) begin
      dmem_we    <= 1'b0;
    end
  end

  // Sticky error: set by a misaligned access or a timeout, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           mem_err <= 1'b0;
    else if (set_err_c) mem_err <= 1'b1;
  end

  // MEM/WB register: either takes the EX/MEM fields or loads an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_wb              <= 32'd0;
      alu_result_wb      <= 32'd0;
      read_data_wb       <= 32'd0;
      write_reg_addr_wb  <= 5'd0;
      mem_to_reg_flag_wb <= 1'b0;
      reg_write_flag_wb  <= 1'b0;
    end else if (wb_load_c) begin
      pc_wb              <= pc_mem;
      alu_result_wb      <= alu_result_mem;
      read_data_wb       <= wb_rdata_c;
      write_reg_addr_wb  <= write_reg_addr_mem;
      mem_to_reg_flag_wb <= mem_to_reg_flag_mem;
      reg_write_flag_wb  <= reg_write_flag_mem;
    end else begin
      pc_wb              <= 32'd0;
      alu_result_wb      <= 32'd0;
      read_data_wb       <= 32'd0;
      write_reg_addr_wb  <= 5'd0;
      mem_to_reg_flag_wb <= 1'b0;
      reg_write_flag_wb  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage (TIMEOUT_CYCLES = 4).
// The driver issues one EX/MEM input set per cycle on the falling edge, and
// pushes the MEM/WB contents that it expects after the next rising edge.
// A monitor pops one entry at each rising edge and compares it with the DUT.
module tb_mem_access_stage;

  localparam int W = 104; // {bubble, pc, alu, rdata, wreg, m2r, rw}

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_mem, alu_result_mem, reg2_data_mem;
  logic        zero_mem, branch_flag_mem, jump_flag_mem;
  logic [4:0]  write_reg_addr_mem;
  logic        mem_to_reg_flag_mem, reg_write_flag_mem, mem_read_flag_mem, mem_write_flag_mem;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, pc_src, mem_err, fsm_state;
  logic [31:0] pc_wb, alu_result_wb, read_data_wb;
  logic [4:0]  write_reg_addr_wb;
  logic        mem_to_reg_flag_wb, reg_write_flag_wb;

  int          checks_total  = 0;
  int          checks_passed = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .pc_mem(pc_mem), .alu_result_mem(alu_result_mem), .reg2_data_mem(reg2_data_mem),
    .zero_mem(zero_mem), .branch_flag_mem(branch_flag_mem), .jump_flag_mem(jump_flag_mem),
    .write_reg_addr_mem(write_reg_addr_mem),
    .mem_to_reg_flag_mem(mem_to_reg_flag_mem), .reg_write_flag_mem(reg_write_flag_mem),
    .mem_read_flag_mem(mem_read_flag_mem), .mem_write_flag_mem(mem_write_flag_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .pc_src(pc_src), .mem_err(mem_err),
    .pc_wb(pc_wb), .alu_result_wb(alu_result_wb), .read_data_wb(read_data_wb),
    .write_reg_addr_wb(write_reg_addr_wb),
    .mem_to_reg_flag_wb(mem_to_reg_flag_wb), .reg_write_flag_wb(reg_write_flag_wb),
    .fsm_state(fsm_state)
  );

  // ---------------- check helpers ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] wb_pkt(input logic bub, input logic [31:0] pc,
                                          input logic [31:0] alu, input logic [31:0] rd,
                                          input logic [4:0] wa, input logic m2r, input logic rw);
    return {bub, pc, alu, rd, wa, m2r, rw};
  endfunction

  function automatic logic [W-1:0] bubble();
    return wb_pkt(1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [W-1:0] nop_wb();
    return wb_pkt(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_ex(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] wa, input logic m2r, input logic rw,
                          input logic rd, input logic wr);
    pc_mem              = pc;
    alu_result_mem      = alu;
    reg2_data_mem       = wd;
    write_reg_addr_mem  = wa;
    mem_to_reg_flag_mem = m2r;
    reg_write_flag_mem  = rw;
    mem_read_flag_mem   = rd;
    mem_write_flag_mem  = wr;
  endtask

  task automatic drive_nop();
    drive_ex(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_req"}, dmem_req, 1'b0);
    check1({tag, "_we"}, dmem_we, 1'b0);
    check32({tag, "_addr"}, dmem_addr, 32'd0);
    check32({tag, "_wdata"}, dmem_wdata, 32'd0);
    check1({tag, "_err"}, mem_err, 1'b0);
    check1({tag, "_stall"}, mem_stall, 1'b0);
    check1({tag, "_state"}, fsm_state, 1'b0);
    check32({tag, "_pc_wb"}, pc_wb, 32'd0);
    check32({tag, "_alu_wb"}, alu_result_wb, 32'd0);
    check32({tag, "_rdata_wb"}, read_data_wb, 32'd0);
    check1({tag, "_rw_wb"}, reg_write_flag_wb, 1'b0);
    check1({tag, "_m2r_wb"}, mem_to_reg_flag_wb, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b0;
    drive_nop();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e[103]) begin
        check1("wb_bubble_rw", reg_write_flag_wb, 1'b0);
        check1("wb_bubble_m2r", mem_to_reg_flag_wb, 1'b0);
      end else begin
        check32("wb_pc", pc_wb, mon_e[102:71]);
        check32("wb_alu", alu_result_wb, mon_e[70:39]);
        check32("wb_rdata", read_data_wb, mon_e[38:7]);
        check32("wb_wreg", {27'd0, write_reg_addr_wb}, {27'd0, mon_e[6:2]});
        check1("wb_m2r", mem_to_reg_flag_wb, mon_e[1]);
        check1("wb_rw", reg_write_flag_wb, mon_e[0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    zero_mem = 1'b0;
    branch_flag_mem = 1'b0;
    jump_flag_mem = 1'b1;
    // Aligned load present during reset: must not stall; pc_src stays live.
    drive_ex(32'h44, 32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    check_reset_outputs("init");
    check1("rst_pc_src_live", pc_src, 1'b1);
    @(negedge clk);
    jump_flag_mem = 1'b0;
    drive_nop();
    @(negedge clk);
    rst = 1'b1;

    // ALU op passes straight through to MEM/WB
    @(negedge clk);
    drive_ex(32'h40, 32'h10, 32'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; check1("alu_stall", mem_stall, 1'b0);
    exp_q.push_back(wb_pkt(1'b0, 32'h40, 32'h10, 32'd0, 5'd5, 1'b0, 1'b1));

    // Load at 0x100; the ack comes on the third ACCESS cycle
    @(negedge clk);
    drive_ex(32'h44, 32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    #1; check1("ld_idle_stall", mem_stall, 1'b1); check1("ld_idle_req", dmem_req, 1'b0);
    exp_q.push_back(bubble());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check1("ld_req", dmem_req, 1'b1);
      check32("ld_addr", dmem_addr, 32'h100);
      check1("ld_we", dmem_we, 1'b0);
      check1("ld_stall", mem_stall, 1'b1);
      exp_q.push_back(bubble());
    end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1; check1("ld_ack_stall", mem_stall, 1'b0); check1("ld_ack_req", dmem_req, 1'b1);
    exp_q.push_back(wb_pkt(1'b0, 32'h44, 32'h100, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1));
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'd0; drive_nop();
    #1; check1("ld_done_req", dmem_req, 1'b0); check1("ld_err", mem_err, 1'b0);
    exp_q.push_back(nop_wb());

    // Store with both read and write flags set; ack on the first ACCESS cycle
    @(negedge clk);
    drive_ex(32'h48, 32'h204, 32'h12345678, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    #1; check1("st_idle_stall", mem_stall, 1'b1);
    exp_q.push_back(bubble());
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    check1("st_req", dmem_req, 1'b1);
    check1("st_we", dmem_we, 1'b1);
    check32("st_wdata", dmem_wdata, 32'h12345678);
    check32("st_addr", dmem_addr, 32'h204);
    check1("st_stall", mem_stall, 1'b0);
    exp_q.push_back(wb_pkt(1'b0, 32'h48, 32'h204, 32'd0, 5'd3, 1'b0, 1'b0));
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'd0; drive_nop();
    #1; check1("st_done_req", dmem_req, 1'b0);
    exp_q.push_back(nop_wb());

    // Misaligned load at 0x102
    @(negedge clk);
    drive_ex(32'h4C, 32'h102, 32'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    #1; check1("mis_stall", mem_stall, 1'b0); check1("mis_req", dmem_req, 1'b0);
    exp_q.push_back(bubble());
    @(negedge clk);
    drive_nop();
    #1; check1("mis_req_after", dmem_req, 1'b0); check1("mis_err", mem_err, 1'b1);
    exp_q.push_back(nop_wb());

    // An ack that arrives while IDLE is ignored; the error flag stays set
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h55;
    #1; check1("idle_ack_req", dmem_req, 1'b0);
    exp_q.push_back(nop_wb());
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    #1; check1("idle_ack_state", fsm_state, 1'b0); check1("err_sticky", mem_err, 1'b1);
    exp_q.push_back(nop_wb());

    // pc_src combinations
    @(negedge clk); branch_flag_mem = 1'b1; zero_mem = 1'b1;
    #1; check1("pcsrc_br_z", pc_src, 1'b1); exp_q.push_back(nop_wb());
    @(negedge clk); zero_mem = 1'b0;
    #1; check1("pcsrc_br_nz", pc_src, 1'b0); exp_q.push_back(nop_wb());
    @(negedge clk); branch_flag_mem = 1'b0; jump_flag_mem = 1'b1;
    #1; check1("pcsrc_jmp", pc_src, 1'b1); exp_q.push_back(nop_wb());
    @(negedge clk); jump_flag_mem = 1'b0;
    #1; check1("pcsrc_none", pc_src, 1'b0); exp_q.push_back(nop_wb());

    // Timeout with no ack: abort after four ACCESS cycles
    do_reset();
    @(negedge clk);
    drive_ex(32'h50, 32'h200, 32'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    #1; check1("to_idle_stall", mem_stall, 1'b1);
    exp_q.push_back(bubble());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check1("to_req", dmem_req, 1'b1);
      check1("to_stall", mem_stall, (i < 3) ? 1'b1 : 1'b0);
      exp_q.push_back(bubble());
    end
    @(negedge clk);
    drive_nop();
    #1; check1("to_req_after", dmem_req, 1'b0); check1("to_err", mem_err, 1'b1);
    exp_q.push_back(nop_wb());

    // The ack arrives on the fourth ACCESS cycle: normal completion, no error
    do_reset();
    @(negedge clk);
    drive_ex(32'h54, 32'h200, 32'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    #1; exp_q.push_back(bubble());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check1("ack4_stall", mem_stall, 1'b1);
      exp_q.push_back(bubble());
    end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1; check1("ack4_stall_last", mem_stall, 1'b0);
    exp_q.push_back(wb_pkt(1'b0, 32'h54, 32'h200, 32'hCAFEF00D, 5'd4, 1'b1, 1'b1));
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'd0; drive_nop();
    #1; check1("ack4_err", mem_err, 1'b0); check1("ack4_req", dmem_req, 1'b0);
    exp_q.push_back(nop_wb());

    // Reset asserted in the middle of an access abandons the request at once
    @(negedge clk);
    drive_ex(32'h58, 32'h300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    #1; exp_q.push_back(bubble());
    @(negedge clk);
    #1; check1("mid_req_before", dmem_req, 1'b1);
    #2; rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    drive_nop();
    rst = 1'b1;
    @(negedge clk);
    #1; check1("post_rst_state", fsm_state, 1'b0);

    // Operation resumes normally after reset
    @(negedge clk);
    drive_ex(32'h60, 32'h24, 32'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; exp_q.push_back(wb_pkt(1'b0, 32'h60, 32'h24, 32'd0, 5'd2, 1'b0, 1'b1));
    @(negedge clk);
    drive_nop();

    repeat (2) @(posedge clk);
    #2;
    check32("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
